// File: rtl/mic_pkg.sv
// Shared types and default widths for the MIC-1 microsequencer slice.
package mic_pkg;
    localparam int MIC_ADDR_W      = 9;
    localparam int MIC_MBR_W       = 8;
    localparam int MIC_STACK_DEPTH = 4;
    localparam int MIC_RESET_ADDR  = 0;

    typedef logic [MIC_ADDR_W-1:0] upc_t;

    typedef struct packed {
        logic jmpc;
        logic jamn;
        logic jamz;
        logic call;
        logic ret;
    } jam_t;
endpackage

// File: rtl/mic_ustack.sv
// Microsubroutine return-address LIFO: pointer register over a fixed array.
module mic_ustack #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            din,
    output logic [ADDR_W-1:0]            top,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [DW-1:0]     ptr;
    logic [ADDR_W-1:0] mem [DEPTH];

    assign full  = (ptr == DW'(DEPTH));
    assign empty = (ptr == '0);
    assign depth = ptr;

    // Entry ptr-1 is the top; compare-based select avoids a zero-width index at DEPTH=1.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr == DW'(i + 1)) top = mem[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr == DW'(i)) mem[i] <= din;
            end
            ptr <= ptr + 1'b1;
        end else if (pop && !empty) begin
            ptr <= ptr - 1'b1;
        end
    end
endmodule

// File: rtl/mic_sequencer.sv
// MIC-1 microsequencer: next-address mux (JAM/JMPC), call/return stack and MPC register.
module mic_sequencer #(
    parameter int ADDR_W      = mic_pkg::MIC_ADDR_W,
    parameter int MBR_W       = mic_pkg::MIC_MBR_W,
    parameter int STACK_DEPTH = mic_pkg::MIC_STACK_DEPTH,
    parameter int RESET_ADDR  = mic_pkg::MIC_RESET_ADDR
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [ADDR_W-1:0]                  next_addr,
    input  logic                               jmpc,
    input  logic                               jamn,
    input  logic                               jamz,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               n,
    input  logic                               z,
    input  logic [MBR_W-1:0]                   mbr,
    input  logic                               stall,
    output logic [ADDR_W-1:0]                  mpc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp_depth,
    output logic                               stack_err
);
    import mic_pkg::*;

    jam_t              ctl;
    logic              high;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] stack_top;
    logic              stack_full;
    logic              stack_empty;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        ctl    = '{jmpc: jmpc, jamn: jamn, jamz: jamz, call: call, ret: ret};
        high   = (ctl.jamz & z) | (ctl.jamn & n);
        target = next_addr;
        target[ADDR_W-1] = target[ADDR_W-1] | high;
        // MBR_W < ADDR_W, so JMPC never touches the JAM-controlled high bit.
        if (ctl.jmpc) target[MBR_W-1:0] = target[MBR_W-1:0] | mbr;
    end

    // ret outranks call; a stalled cycle neither pushes nor pops.
    assign do_push = !stall && ctl.call && !ctl.ret;
    assign do_pop  = !stall && ctl.ret && !stack_empty;

    mic_ustack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (do_push),
        .pop   (do_pop),
        .din   (mpc + 1'b1),
        .top   (stack_top),
        .full  (stack_full),
        .empty (stack_empty),
        .depth (sp_depth)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mpc       <= ADDR_W'(RESET_ADDR);
            stack_err <= 1'b0;
        end else if (!stall) begin
            if (ctl.ret && !stack_empty) mpc <= stack_top;
            else                         mpc <= target;
            if ((ctl.ret && (stack_empty || ctl.call)) || (do_push && stack_full))
                stack_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mic_sequencer.sv
// Directed bench for mic_sequencer: one task per scenario, inline checks, one summary line.
module tb_mic_sequencer;
    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] next_addr;
    logic       jmpc, jamn, jamz, call, ret, n, z, stall;
    logic [7:0] mbr;
    logic [8:0] mpc;
    logic [2:0] sp_depth;
    logic       stack_err;

    int tests_run    = 0;
    int tests_failed = 0;

    mic_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .next_addr (next_addr),
        .jmpc      (jmpc),
        .jamn      (jamn),
        .jamz      (jamz),
        .call      (call),
        .ret       (ret),
        .n         (n),
        .z         (z),
        .mbr       (mbr),
        .stall     (stall),
        .mpc       (mpc),
        .sp_depth  (sp_depth),
        .stack_err (stack_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        jmpc = 0; jamn = 0; jamz = 0; call = 0; ret = 0;
        n = 0; z = 0; mbr = '0; stall = 0;
    endtask

    task automatic test_reset();
        clear_ctl();
        next_addr = 9'h005;
        reset = 1'b0;
        tick();
        tick();
        tests_run++; if (mpc !== 9'h000) begin tests_failed++; $display("FAIL reset_mpc: got %h want 000", mpc); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL reset_depth: got %0d want 0", sp_depth); end
        tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", stack_err); end
        reset = 1'b1;
        tick();
        tests_run++; if (mpc !== 9'h005) begin tests_failed++; $display("FAIL first_clk_mpc: got %h want 005", mpc); end
        tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL first_clk_err: got %b want 0", stack_err); end
    endtask

    task automatic test_jam();
        clear_ctl();
        next_addr = 9'h092; jamz = 1; z = 1;
        tick();
        tests_run++; if (mpc !== 9'h192) begin tests_failed++; $display("FAIL jamz_z1: got %h want 192", mpc); end
        z = 0;
        tick();
        tests_run++; if (mpc !== 9'h092) begin tests_failed++; $display("FAIL jamz_z0: got %h want 092", mpc); end
        jamz = 0; jamn = 1; n = 1;
        tick();
        tests_run++; if (mpc !== 9'h192) begin tests_failed++; $display("FAIL jamn_n1: got %h want 192", mpc); end
        n = 0;
        tick();
        tests_run++; if (mpc !== 9'h092) begin tests_failed++; $display("FAIL jamn_n0: got %h want 092", mpc); end
        jamn = 0; z = 1; n = 1;
        tick();
        tests_run++; if (mpc !== 9'h092) begin tests_failed++; $display("FAIL flags_no_jam: got %h want 092", mpc); end
    endtask

    task automatic test_jmpc_stall();
        clear_ctl();
        next_addr = 9'h100; jmpc = 1; mbr = 8'h60;
        tick();
        tests_run++; if (mpc !== 9'h160) begin tests_failed++; $display("FAIL jmpc: got %h want 160", mpc); end
        jmpc = 0; next_addr = 9'h030;
        tick();
        tests_run++; if (mpc !== 9'h030) begin tests_failed++; $display("FAIL pre_stall: got %h want 030", mpc); end
        next_addr = 9'h100; jmpc = 1; mbr = 8'h60; stall = 1; call = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++; if (mpc !== 9'h030) begin tests_failed++; $display("FAIL stall_hold_%0d: got %h want 030", i, mpc); end
            tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL stall_no_push_%0d: got %0d want 0", i, sp_depth); end
        end
        stall = 0; call = 0;
        tick();
        tests_run++; if (mpc !== 9'h160) begin tests_failed++; $display("FAIL post_stall: got %h want 160", mpc); end
    endtask

    task automatic test_call_ret();
        clear_ctl();
        next_addr = 9'h020;
        tick();
        call = 1; next_addr = 9'h080;
        tick();
        tests_run++; if (mpc !== 9'h080) begin tests_failed++; $display("FAIL call_mpc: got %h want 080", mpc); end
        tests_run++; if (sp_depth !== 3'd1) begin tests_failed++; $display("FAIL call_depth: got %0d want 1", sp_depth); end
        call = 0; ret = 1; next_addr = 9'h000;
        tick();
        tests_run++; if (mpc !== 9'h021) begin tests_failed++; $display("FAIL ret_mpc: got %h want 021", mpc); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL ret_depth: got %0d want 0", sp_depth); end
        tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL ret_err: got %b want 0", stack_err); end
    endtask

    // Starts at mpc=021: pushes 022,041,051,061; fifth push (071) is dropped.
    task automatic test_overflow();
        logic [8:0] call_tgt [5] = '{9'h040, 9'h050, 9'h060, 9'h070, 9'h0A0};
        logic [8:0] ret_exp  [5] = '{9'h061, 9'h051, 9'h041, 9'h022, 9'h1F0};
        clear_ctl();
        call = 1;
        for (int i = 0; i < 5; i++) begin
            next_addr = call_tgt[i];
            tick();
            tests_run++; if (mpc !== call_tgt[i]) begin tests_failed++; $display("FAIL nest_call_%0d: got %h want %h", i, mpc, call_tgt[i]); end
            if (i == 3) begin
                tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL full_no_err: got %b want 0", stack_err); end
            end
        end
        tests_run++; if (sp_depth !== 3'd4) begin tests_failed++; $display("FAIL ovf_depth: got %0d want 4", sp_depth); end
        tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL ovf_err: got %b want 1", stack_err); end
        call = 0; ret = 1; next_addr = 9'h1F0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (mpc !== ret_exp[i]) begin tests_failed++; $display("FAIL unwind_%0d: got %h want %h", i, mpc, ret_exp[i]); end
            tests_run++; if (sp_depth !== 3'(i < 4 ? 3 - i : 0)) begin tests_failed++; $display("FAIL unwind_depth_%0d: got %0d", i, sp_depth); end
        end
        tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b want 1", stack_err); end
    endtask

    task automatic test_err_cases();
        clear_ctl();
        next_addr = 9'h000;
        reset = 0; #2; reset = 1;
        tick();
        tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared: got %b want 0", stack_err); end
        // call+ret on empty stack: takes target, no push.
        call = 1; ret = 1; next_addr = 9'h044;
        tick();
        tests_run++; if (mpc !== 9'h044) begin tests_failed++; $display("FAIL callret_empty_mpc: got %h want 044", mpc); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL callret_empty_depth: got %0d want 0", sp_depth); end
        tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL callret_empty_err: got %b want 1", stack_err); end
        reset = 0; #2; reset = 1;
        // mpc=000: call pushes 001, then call+ret pops it.
        ret = 0; call = 1; next_addr = 9'h010;
        tick();
        tests_run++; if (sp_depth !== 3'd1) begin tests_failed++; $display("FAIL pre_callret_depth: got %0d want 1", sp_depth); end
        ret = 1; next_addr = 9'h0EE;
        tick();
        tests_run++; if (mpc !== 9'h001) begin tests_failed++; $display("FAIL callret_mpc: got %h want 001", mpc); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL callret_depth: got %0d want 0", sp_depth); end
        tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL callret_err: got %b want 1", stack_err); end
        ret = 0; call = 1; next_addr = 9'h077;
        tick();
        #2 reset = 0;
        #1;
        tests_run++; if (mpc !== 9'h000) begin tests_failed++; $display("FAIL midreset_mpc: got %h want 000", mpc); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL midreset_depth: got %0d want 0", sp_depth); end
        tests_run++; if (stack_err !== 1'b0) begin tests_failed++; $display("FAIL midreset_err: got %b want 0", stack_err); end
        call = 0; next_addr = 9'h033;
        #1 reset = 1;
        tick();
        tests_run++; if (mpc !== 9'h033) begin tests_failed++; $display("FAIL after_reset_mpc: got %h want 033", mpc); end
        // Old entry must be gone: ret now falls through to target.
        ret = 1; next_addr = 9'h055;
        tick();
        tests_run++; if (mpc !== 9'h055) begin tests_failed++; $display("FAIL ret_empty_mpc: got %h want 055", mpc); end
        tests_run++; if (stack_err !== 1'b1) begin tests_failed++; $display("FAIL ret_empty_err: got %b want 1", stack_err); end
        tests_run++; if (sp_depth !== 3'd0) begin tests_failed++; $display("FAIL ret_empty_depth: got %0d want 0", sp_depth); end
    endtask

    initial begin
        reset = 1'b0;
        next_addr = '0;
        clear_ctl();
        #1;
        test_reset();
        test_jam();
        test_jmpc_stall();
        test_call_ret();
        test_overflow();
        test_err_cases();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
